// File: rtl/echo_hit_scanner_pkg.sv
// Shared widths, state encoding and bit-decode helper for the echo-hit scanner.
package echo_scan_pkg;

    localparam int IDX_W  = 6;
    localparam int CNT_W  = 7;
    localparam int MASK_W = 64;

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    function automatic logic [MASK_W-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(MASK_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/echo_hit_scanner_clz64.sv
// Count of leading zeros of a 64-bit word; y = 64 when x is all-zero.
module clz64 (
    input  logic [63:0] x,
    output logic [6:0]  y
);

    // Ascending scan: the highest set bit is the last to assign y.
    always_comb begin
        y = 7'd64;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) y = 7'(63 - i);
        end
    end

endmodule

// File: rtl/echo_hit_scanner.sv
// Serialises a 64-bit echo-hit mask into bin-index beats, latest bin first,
// one beat per clock, with a single flagged beat for empty masks and a hit cap.
module echo_hit_scanner
    import echo_scan_pkg::*;
#(
    parameter int TAG_W    = 16,
    parameter int MAX_HITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MASK_W-1:0] in_mask,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [CNT_W-1:0]  out_rank,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_last,
    output logic              out_none,
    output logic              out_trunc
);

    scan_state_t       state, state_n;
    logic [MASK_W-1:0] mask_r, mask_n;
    logic [CNT_W-1:0]  rank, rank_n;
    logic [TAG_W-1:0]  tag_r, tag_n;

    logic [CNT_W-1:0]  clz;
    logic [CNT_W-1:0]  top_bit;
    logic [IDX_W-1:0]  idx;
    logic [MASK_W-1:0] residual;
    logic              none, at_cap, last, accept, fire;

    clz64 u_clz (
        .x (mask_r),
        .y (clz)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        top_bit  = 7'd63 - clz;
        none     = (mask_r == '0);
        idx      = none ? '0 : top_bit[IDX_W-1:0];
        residual = mask_r & ~onehot(idx);
        at_cap   = (rank == CNT_W'(MAX_HITS - 1));
        last     = none || (residual == '0) || at_cap;

        out_valid = 1'b0;
        out_idx   = '0;
        out_rank  = '0;
        out_tag   = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        out_trunc = 1'b0;
        if (state == S_SCAN) begin
            out_valid = 1'b1;
            out_idx   = idx;
            out_rank  = rank;
            out_tag   = tag_r;
            out_last  = last;
            out_none  = none;
            out_trunc = at_cap && (residual != '0);
        end

        // Accepting during the final handshake keeps back-to-back masks bubble-free.
        in_ready = !rst && ((state == S_IDLE) || (out_ready && out_last));
        accept   = in_valid && in_ready;
        fire     = out_valid && out_ready;

        state_n = state;
        mask_n  = mask_r;
        rank_n  = rank;
        tag_n   = tag_r;
        if (fire) begin
            if (last) begin
                state_n = S_IDLE;
                mask_n  = '0;
                rank_n  = '0;
            end else begin
                mask_n  = residual;
                rank_n  = rank + 1'b1;
            end
        end
        if (accept) begin
            state_n = S_SCAN;
            mask_n  = in_mask;
            tag_n   = in_tag;
            rank_n  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            mask_r <= '0;
            rank   <= '0;
            tag_r  <= '0;
        end else begin
            state  <= state_n;
            mask_r <= mask_n;
            rank   <= rank_n;
            tag_r  <= tag_n;
        end
    end

endmodule

// File: tb/tb_echo_hit_scanner.sv
// Self-checking bench: two scanner instances (MAX_HITS 64 and 4) against a
// bit-walking reference model, with directed cases and randomized masks/stalls.
module tb_echo_hit_scanner;

    localparam int TAG_W = 16;

    typedef struct {
        logic [5:0] idx;
        logic [6:0] rank;
        logic       last;
        logic       none;
        logic       trunc;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sel = 1'b0;
    logic             in_valid = 1'b0;
    logic [63:0]      in_mask = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b0;

    logic             a_in_ready, a_out_valid, a_out_last, a_out_none, a_out_trunc;
    logic [5:0]       a_out_idx;
    logic [6:0]       a_out_rank;
    logic [TAG_W-1:0] a_out_tag;
    logic             b_in_ready, b_out_valid, b_out_last, b_out_none, b_out_trunc;
    logic [5:0]       b_out_idx;
    logic [6:0]       b_out_rank;
    logic [TAG_W-1:0] b_out_tag;

    logic             o_in_ready, o_valid, o_last, o_none, o_trunc;
    logic [5:0]       o_idx;
    logic [6:0]       o_rank;
    logic [TAG_W-1:0] o_tag;

    int    passed = 0;
    int    total  = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    echo_hit_scanner #(.TAG_W(TAG_W), .MAX_HITS(64)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && !sel),
        .in_ready  (a_in_ready),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .out_valid (a_out_valid),
        .out_ready (out_ready && !sel),
        .out_idx   (a_out_idx),
        .out_rank  (a_out_rank),
        .out_tag   (a_out_tag),
        .out_last  (a_out_last),
        .out_none  (a_out_none),
        .out_trunc (a_out_trunc)
    );

    echo_hit_scanner #(.TAG_W(TAG_W), .MAX_HITS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && sel),
        .in_ready  (b_in_ready),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .out_valid (b_out_valid),
        .out_ready (out_ready && sel),
        .out_idx   (b_out_idx),
        .out_rank  (b_out_rank),
        .out_tag   (b_out_tag),
        .out_last  (b_out_last),
        .out_none  (b_out_none),
        .out_trunc (b_out_trunc)
    );

    assign o_in_ready = sel ? b_in_ready  : a_in_ready;
    assign o_valid    = sel ? b_out_valid : a_out_valid;
    assign o_idx      = sel ? b_out_idx   : a_out_idx;
    assign o_rank     = sel ? b_out_rank  : a_out_rank;
    assign o_tag      = sel ? b_out_tag   : a_out_tag;
    assign o_last     = sel ? b_out_last  : a_out_last;
    assign o_none     = sel ? b_out_none  : a_out_none;
    assign o_trunc    = sel ? b_out_trunc : a_out_trunc;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    // Reference: walk bits from 63 down, keep the first maxh hits, flag any surplus.
    task automatic build_expected(input logic [63:0] mask, input int maxh);
        int cnt = 0;
        beat_t b;
        exp_q.delete();
        if (mask == '0) begin
            b = '{idx: 6'd0, rank: 7'd0, last: 1'b1, none: 1'b1, trunc: 1'b0};
            exp_q.push_back(b);
            return;
        end
        for (int bit_i = 63; bit_i >= 0; bit_i--) begin
            if (mask[bit_i]) begin
                if (cnt < maxh) begin
                    b = '{idx: 6'(bit_i), rank: 7'(cnt), last: 1'b0, none: 1'b0, trunc: 1'b0};
                    exp_q.push_back(b);
                end
                cnt++;
            end
        end
        exp_q[exp_q.size()-1].last  = 1'b1;
        exp_q[exp_q.size()-1].trunc = (cnt > maxh);
    endtask

    task automatic check_beat(input beat_t b, input logic [TAG_W-1:0] tag);
        check("out_valid", o_valid, 1'b1);
        check("out_idx",   o_idx,   b.idx);
        check("out_rank",  o_rank,  b.rank);
        check("out_tag",   o_tag,   tag);
        check("out_last",  o_last,  b.last);
        check("out_none",  o_none,  b.none);
        check("out_trunc", o_trunc, b.trunc);
        check("in_ready_scan", o_in_ready, out_ready && b.last);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"},    o_valid,    1'b0);
        check({name, "_idx"},      o_idx,      6'd0);
        check({name, "_last"},     o_last,     1'b0);
        check({name, "_in_ready"}, o_in_ready, 1'b1);
    endtask

    // Entered and left just after a posedge. first_stall holds out_ready low on
    // the first beat; later beats stall with probability stall_pct percent.
    task automatic run_mask(input logic [63:0] mask, input logic [TAG_W-1:0] tag,
                            input int first_stall, input int stall_pct);
        int stalls;
        build_expected(mask, sel ? 4 : 64);
        in_valid  = 1'b1;
        in_mask   = mask;
        in_tag    = tag;
        out_ready = 1'b0;
        @(negedge clk);
        check("in_ready_idle", o_in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            stalls = 0;
            do begin
                if (i == 0 && stalls < first_stall) out_ready = 1'b0;
                else out_ready = ($urandom_range(99) >= 32'(stall_pct));
                stalls++;
                @(negedge clk);
                check_beat(exp_q[i], tag);
                @(posedge clk); #1;
            end while (!out_ready);
        end
        out_ready = 1'b0;
        @(negedge clk);
        check_idle("post_mask");
        @(posedge clk); #1;
    endtask

    logic [63:0] rmask;

    initial begin
        // Reset: in_ready low while rst is asserted, outputs at reset values after.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_rst", o_in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        check("reset_rank",  o_rank,  7'd0);
        check("reset_tag",   o_tag,   16'd0);
        check("reset_none",  o_none,  1'b0);
        check("reset_trunc", o_trunc, 1'b0);
        @(posedge clk); #1;

        // Two-hit mask at the extreme bins, empty mask, backpressure hold.
        run_mask(64'h8000_0000_0000_0001, 16'h1234, 0, 0);
        run_mask(64'h0, 16'h00A5, 0, 0);
        run_mask(64'h30, 16'h0030, 3, 0);

        // Back-to-back: mask B accepted during A's last beat, no bubble.
        in_valid = 1'b1; in_mask = 64'h3; in_tag = 16'hAAAA; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_a_idx1", o_idx, 6'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mask = 64'h1; in_tag = 16'hBBBB;
        @(negedge clk);
        check("b2b_a_idx0", o_idx, 6'd0);
        check("b2b_a_last", o_last, 1'b1);
        check("b2b_in_ready", o_in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("b2b_b_valid", o_valid, 1'b1);
        check("b2b_b_idx", o_idx, 6'd0);
        check("b2b_b_tag", o_tag, 16'hBBBB);
        check("b2b_b_rank", o_rank, 7'd0);
        check("b2b_b_last", o_last, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_idle("b2b_end");
        @(posedge clk); #1;

        // Reset mid-scan after beats idx7 and idx6.
        in_valid = 1'b1; in_mask = 64'hFF; in_tag = 16'h0FF0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); check("rst_scan_idx7", o_idx, 6'd7);
        @(posedge clk); #1;
        @(negedge clk); check("rst_scan_idx6", o_idx, 6'd6);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); check("rst_scan_in_ready", o_in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check_idle("rst_scan");
        check("rst_scan_tag", o_tag, 16'd0);
        @(posedge clk); #1;
        run_mask(64'hFF, 16'h0F0F, 0, 0);

        // MAX_HITS=4 instance: full mask truncates after idx60.
        sel = 1'b1;
        run_mask({64{1'b1}}, 16'h4444, 0, 0);
        run_mask(64'h0, 16'h0044, 0, 0);

        // Randomized masks and backpressure on both instances.
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int n = 0; n < 25; n++) begin
                case ($urandom_range(4))
                    0: rmask = '0;
                    1: rmask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    2: rmask = 64'h1 << $urandom_range(63);
                    3: rmask = ~(64'h1 << $urandom_range(63));
                    default: rmask = {$urandom, $urandom};
                endcase
                run_mask(rmask, 16'($urandom), $urandom_range(2), 30);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
